// File: rtl/alu_packet_ctrl.sv
// Packet sequencer for the UART ALU: parses a 4-byte header, then echoes the payload,
// sums it or multiplies it through an external multiplier, and streams the result back.
module alu_packet_ctrl #(
  parameter int OPERAND_W = 32,
  parameter int LEN_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [OPERAND_W-1:0] mul_a_o,
  output logic [OPERAND_W-1:0] mul_b_o,
  output logic                 mul_valid_o,
  input  logic                 mul_ready_i,
  input  logic [OPERAND_W-1:0] mul_result_i,
  input  logic                 mul_done_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int NB     = OPERAND_W / 8;
  localparam int BIDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TXI_W  = BIDX_W + 1;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;

  typedef enum logic [3:0] {
    S_RX_OPCODE, S_RX_RESERVED, S_RX_LEN_LSB, S_RX_LEN_MSB,
    S_ECHO, S_ADD, S_MUL, S_MUL_WAIT, S_TRANSMIT, S_DRAIN
  } state_t;

  state_t                r_state;
  logic                  r_armed;
  logic [7:0]            r_op;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic [BIDX_W-1:0]     r_bidx;
  logic [TXI_W-1:0]      r_tx_idx;
  logic [OPERAND_W-1:0]  r_word;
  logic [OPERAND_W-1:0]  r_acc;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic [OPERAND_W-1:0]  r_mul_a;
  logic [OPERAND_W-1:0]  r_mul_b;
  logic                  r_mul_valid;
  logic                  r_err;

  logic                  w_rx_ready;
  logic                  w_rx_fire;
  logic [LEN_W-1:0]      w_len;
  logic [LEN_W-1:0]      w_pay;
  logic                  w_last_byte;
  logic                  w_word_done;
  logic [OPERAND_W-1:0]  w_word_nxt;
  logic [7:0]            w_acc_byte;

  // rx_ready is held low for the first cycle after reset so reset leaves every output at 0
  always_comb begin
    w_rx_ready = 1'b0;
    case (r_state)
      S_RX_OPCODE, S_RX_RESERVED, S_RX_LEN_LSB, S_RX_LEN_MSB,
      S_ADD, S_MUL, S_DRAIN: w_rx_ready = 1'b1;
      S_ECHO:                w_rx_ready = ~r_tx_valid;
      default:               w_rx_ready = 1'b0;
    endcase
  end

  assign rx_ready_o  = r_armed & w_rx_ready;
  assign w_rx_fire   = rx_valid_i & rx_ready_o;
  assign w_len       = LEN_W'({rx_data_i, r_len[7:0]});
  assign w_pay       = (w_len < LEN_W'(4)) ? '0 : (w_len - LEN_W'(4));
  assign w_last_byte = ((r_cnt + LEN_W'(1)) == r_len);
  assign w_word_done = (r_bidx == BIDX_W'(NB - 1)) | w_last_byte;

  always_comb begin
    w_word_nxt = r_word;
    w_acc_byte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (r_bidx == BIDX_W'(b)) w_word_nxt[8*b +: 8] = rx_data_i;
      if (r_tx_idx == TXI_W'(b)) w_acc_byte = r_acc[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_RX_OPCODE;
      r_armed     <= 1'b0;
      r_op        <= 8'h00;
      r_len       <= '0;
      r_cnt       <= '0;
      r_bidx      <= '0;
      r_tx_idx    <= '0;
      r_word      <= '0;
      r_acc       <= '0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_err   <= 1'b0;
      case (r_state)
        S_RX_OPCODE: if (w_rx_fire) begin
          r_op    <= rx_data_i;
          r_state <= S_RX_RESERVED;
        end
        S_RX_RESERVED: if (w_rx_fire) r_state <= S_RX_LEN_LSB;
        S_RX_LEN_LSB: if (w_rx_fire) begin
          r_len   <= LEN_W'(rx_data_i);
          r_state <= S_RX_LEN_MSB;
        end
        S_RX_LEN_MSB: if (w_rx_fire) begin
          r_len    <= w_pay;
          r_cnt    <= '0;
          r_bidx   <= '0;
          r_word   <= '0;
          r_tx_idx <= '0;
          case (r_op)
            OP_ECHO: r_state <= (w_pay == '0) ? S_RX_OPCODE : S_ECHO;
            OP_ADD: begin
              r_acc   <= '0;
              r_state <= (w_pay == '0) ? S_TRANSMIT : S_ADD;
            end
            OP_MUL: begin
              r_acc   <= OPERAND_W'(1);
              r_state <= (w_pay == '0) ? S_TRANSMIT : S_MUL;
            end
            default: begin
              r_err   <= 1'b1;
              r_state <= (w_pay == '0) ? S_RX_OPCODE : S_DRAIN;
            end
          endcase
        end
        S_ECHO: begin
          if (w_rx_fire) begin
            r_tx_data  <= rx_data_i;
            r_tx_valid <= 1'b1;
            r_cnt      <= r_cnt + LEN_W'(1);
          end else if (r_tx_valid && tx_ready_i) begin
            r_tx_valid <= 1'b0;
            if (r_cnt == r_len) r_state <= S_RX_OPCODE;
          end
        end
        S_ADD, S_MUL: if (w_rx_fire) begin
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_word_done) begin
            r_word <= '0;
            r_bidx <= '0;
            if (r_state == S_ADD) begin
              r_acc <= r_acc + w_word_nxt;
              if (w_last_byte) r_state <= S_TRANSMIT;
            end else begin
              r_mul_a     <= r_acc;
              r_mul_b     <= w_word_nxt;
              r_mul_valid <= 1'b1;
              r_state     <= S_MUL_WAIT;
            end
          end else begin
            r_word <= w_word_nxt;
            r_bidx <= r_bidx + BIDX_W'(1);
          end
        end
        S_MUL_WAIT: begin
          if (r_mul_valid && mul_ready_i) r_mul_valid <= 1'b0;
          if (mul_done_i) begin
            r_acc   <= mul_result_i;
            r_state <= (r_cnt == r_len) ? S_TRANSMIT : S_MUL;
          end
        end
        // r_tx_idx counts bytes already loaded into the tx register
        S_TRANSMIT: begin
          if (!r_tx_valid) begin
            r_tx_data  <= w_acc_byte;
            r_tx_valid <= 1'b1;
            r_tx_idx   <= r_tx_idx + TXI_W'(1);
          end else if (tx_ready_i) begin
            if (r_tx_idx == TXI_W'(NB)) begin
              r_tx_valid <= 1'b0;
              r_tx_idx   <= '0;
              r_state    <= S_RX_OPCODE;
            end else begin
              r_tx_data <= w_acc_byte;
              r_tx_idx  <= r_tx_idx + TXI_W'(1);
            end
          end
        end
        S_DRAIN: if (w_rx_fire) begin
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_last_byte) r_state <= S_RX_OPCODE;
        end
        default: r_state <= S_RX_OPCODE;
      endcase
    end
  end

  assign tx_data_o   = r_tx_data;
  assign tx_valid_o  = r_tx_valid;
  assign mul_a_o     = r_mul_a;
  assign mul_b_o     = r_mul_b;
  assign mul_valid_o = r_mul_valid;
  assign busy_o      = (r_state != S_RX_OPCODE);
  assign err_o       = r_err;

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Directed bench for alu_packet_ctrl: packet table with expected tx bytes, plus
// hand-written echo timing, tx backpressure and reset-during-multiply sequences.
module tb_alu_packet_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [31:0] mul_a_o, mul_b_o;
  logic        mul_valid_o;
  logic        mul_ready_i = 1'b0;
  logic [31:0] mul_result_i = 32'h0;
  logic        mul_done_i = 1'b0;
  logic        busy_o, err_o;

  alu_packet_ctrl #(.OPERAND_W(32), .LEN_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_valid_o(mul_valid_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i), .mul_done_i(mul_done_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pkt;
    int           np;
    logic [31:0]  exp;
    int           ne;
    int           nerr;
  } vec_t;

  vec_t        vecs [11];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  tx_q [$];
  logic [63:0] req_q [$];
  int          err_cnt = 0;
  int          stab_err = 0;
  int          stall_err = 0;
  bit          chk_stall = 1'b1;
  bit          bp_mode = 1'b0;
  logic [7:0]  bp_pat = 8'b1001_0010;
  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = 8'h00;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // tx sink: record accepted bytes and watch that a stalled byte never changes
  always @(negedge clk) begin
    if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
    if (err_o) err_cnt <= err_cnt + 1;
    if (!rst_i && pv && !pr && (!tx_valid_o || tx_data_o !== pd)) stab_err <= stab_err + 1;
    pv <= tx_valid_o;
    pr <= tx_ready_i;
    pd <= tx_data_o;
  end

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        tx_ready_i = bp_pat[k];
        k = (k + 1) % 8;
      end else begin
        tx_ready_i = 1'b1;
      end
    end
  end

  // multiplier model: ready low for 2 cycles after a request, done pulse 3 cycles after accept
  initial begin
    logic [31:0] a, b;
    forever begin
      @(negedge clk);
      if (mul_valid_o) begin
        a = mul_a_o;
        b = mul_b_o;
        if (chk_stall && rx_ready_o) stall_err++;
        repeat (2) begin
          @(negedge clk);
          if (chk_stall && rx_ready_o) stall_err++;
        end
        mul_ready_i = 1'b1;
        req_q.push_back({a, b});
        @(negedge clk);
        mul_ready_i = 1'b0;
        if (chk_stall && rx_ready_o) stall_err++;
        repeat (2) begin
          @(negedge clk);
          if (chk_stall && rx_ready_o) stall_err++;
        end
        mul_result_i = a * b;
        mul_done_i   = 1'b1;
        @(negedge clk);
        mul_done_i   = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    bit got;
    t = 0;
    got = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!got && t < 500) begin
      @(negedge clk);
      if (rx_ready_o) got = 1'b1;
      else t++;
    end
    if (!got) check("rx_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [127:0] pkt, input int np);
    for (int i = 0; i < np; i++) send_byte(pkt[8*(np-1-i) +: 8]);
  endtask

  task automatic wait_idle(input int ne);
    int t;
    t = 0;
    while (!(busy_o == 1'b0 && tx_q.size() >= ne) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("idle_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_tx(input string nm, input logic [31:0] exp, input int ne);
    logic [7:0] got;
    check({nm, "_tx_count"}, 64'(tx_q.size()), 64'(ne));
    for (int i = 0; i < ne; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      check($sformatf("%s_tx_byte%0d", nm, i), 64'(got), 64'(exp[8*(ne-1-i) +: 8]));
    end
  endtask

  initial begin
    logic [7:0] echo_b;
    int e0;

    vecs[0]  = '{128'hEC_00_07_00_41_42_43, 7, 32'h41_42_43, 3, 0};
    vecs[1]  = '{128'hAD_00_0C_00_FF_FF_FF_FF_02_00_00_00, 12, 32'h01_00_00_00, 4, 0};
    vecs[2]  = '{128'hAD_00_04_00, 4, 32'h00_00_00_00, 4, 0};
    vecs[3]  = '{128'hAD_00_07_00_10_20_30, 7, 32'h10_20_30_00, 4, 0};
    vecs[4]  = '{128'h88_00_0C_00_03_00_00_00_05_00_00_00, 12, 32'h0F_00_00_00, 4, 0};
    vecs[5]  = '{128'h88_00_04_00, 4, 32'h01_00_00_00, 4, 0};
    vecs[6]  = '{128'hD1_00_06_00_AA_BB, 6, 32'h0, 0, 1};
    vecs[7]  = '{128'hEC_00_05_00_99, 5, 32'h99, 1, 0};
    vecs[8]  = '{128'hEC_00_02_00, 4, 32'h0, 0, 0};
    vecs[9]  = '{128'h88_00_06_00_07_01, 6, 32'h07_01_00_00, 4, 0};
    vecs[10] = '{128'hAD_00_08_00_78_56_34_12, 8, 32'h78_56_34_12, 4, 0};

    #2 rst_i = 1'b1;
    #1;
    check("rst_rx_ready",  64'(rx_ready_o),  64'd0);
    check("rst_tx_valid",  64'(tx_valid_o),  64'd0);
    check("rst_tx_data",   64'(tx_data_o),   64'd0);
    check("rst_mul_valid", 64'(mul_valid_o), 64'd0);
    check("rst_mul_a",     64'(mul_a_o),     64'd0);
    check("rst_mul_b",     64'(mul_b_o),     64'd0);
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_err",       64'(err_o),       64'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // ECHO timing: each byte shows up on tx the cycle after its rx handshake
    tx_q.delete();
    send_pkt(128'hEC_00_07_00, 4);
    for (int i = 0; i < 3; i++) begin
      echo_b = 8'h41 + 8'(i);
      send_byte(echo_b);
      check($sformatf("echo_valid_next%0d", i), 64'(tx_valid_o), 64'd1);
      check($sformatf("echo_data_next%0d", i),  64'(tx_data_o),  64'(echo_b));
    end
    wait_idle(3);
    check("echo_back_idle", 64'(busy_o), 64'd0);
    check_tx("echo_seq", 32'h41_42_43, 3);

    for (int v = 0; v < 11; v++) begin
      tx_q.delete();
      e0 = err_cnt;
      send_pkt(vecs[v].pkt, vecs[v].np);
      wait_idle(vecs[v].ne);
      check_tx($sformatf("vec%0d", v), vecs[v].exp, vecs[v].ne);
      check($sformatf("vec%0d_err_pulses", v), 64'(err_cnt - e0), 64'(vecs[v].nerr));
    end

    check("mul_req_count", 64'(req_q.size()), 64'd3);
    if (req_q.size() == 3) begin
      check("mul_req0", req_q[0], 64'h00000001_00000003);
      check("mul_req1", req_q[1], 64'h00000003_00000005);
      check("mul_req2", req_q[2], 64'h00000001_00000107);
    end
    check("mul_wait_rx_stall", 64'(stall_err), 64'd0);

    // tx backpressure on an ADD result
    tx_q.delete();
    bp_mode = 1'b1;
    send_pkt(128'hAD_00_08_00_EF_BE_AD_DE, 8);
    wait_idle(4);
    bp_mode = 1'b0;
    check_tx("bp", 32'hEF_BE_AD_DE, 4);
    check("bp_tx_stable", 64'(stab_err), 64'd0);

    // reset while waiting on the multiplier; its done pulse then lands mid-header
    chk_stall = 1'b0;
    tx_q.delete();
    send_pkt(128'h88_00_08_00_02_00_00_00, 8);
    check("mulw_valid", 64'(mul_valid_o), 64'd1);
    check("mulw_b",     64'(mul_b_o),     64'd2);
    check("mulw_rx_ready", 64'(rx_ready_o), 64'd0);
    @(negedge clk);
    #1 rst_i = 1'b1;
    #1;
    check("mrst_busy",      64'(busy_o),      64'd0);
    check("mrst_mul_valid", 64'(mul_valid_o), 64'd0);
    check("mrst_mul_a",     64'(mul_a_o),     64'd0);
    check("mrst_mul_b",     64'(mul_b_o),     64'd0);
    check("mrst_rx_ready",  64'(rx_ready_o),  64'd0);
    check("mrst_tx_valid",  64'(tx_valid_o),  64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    e0 = err_cnt;
    send_pkt(128'hEC_00_05_00_5A, 5);
    wait_idle(1);
    check_tx("post_rst_echo", 32'h5A, 1);
    check("post_rst_err", 64'(err_cnt - e0), 64'd0);
    check("post_rst_idle", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_packet_ctrl.md
Name: alu_packet_ctrl

Overview:
Packet sequencer for the UART ALU. It sits between the UART RX/TX byte streams and the arithmetic datapath. It parses the 4-byte header (opcode, reserved, length LSB, length MSB), then runs ECHO, ADD or MUL over the payload and streams results back as bytes. MUL uses the shared multiplier through a valid/ready request and done-pulse handshake.

Parameters:
OPERAND_W, 32, operand/result width in bits; must be a multiple of 8.
LEN_W, 16, width of header length field.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
rx_data_i  input  8  received byte
rx_valid_i  input  1  rx byte valid
rx_ready_o  output  1  controller accepts rx byte; transfer when valid&ready
tx_data_o  output  8  byte to transmit
tx_valid_o  output  1  tx byte valid; held stable until accepted
tx_ready_i  input  1  transmitter accepts byte
mul_a_o  output  OPERAND_W  multiplier operand A (accumulator)
mul_b_o  output  OPERAND_W  multiplier operand B (payload word)
mul_valid_o  output  1  multiply request
mul_ready_i  input  1  multiplier accepts request
mul_result_i  input  OPERAND_W  product, low OPERAND_W bits
mul_done_i  input  1  one-cycle pulse, mul_result_i valid
busy_o  output  1  high in any state other than RX_OPCODE
err_o  output  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset, asynchronous on rst_i high: state=RX_OPCODE. rx_ready_o=0, tx_valid_o=0, tx_data_o=0, mul_valid_o=0, mul_a_o=0, mul_b_o=0, busy_o=0, err_o=0. Accumulator, length and byte counters=0. Reset mid-packet abandons the packet with no output. Following bytes are parsed as a new header.
- Opcodes: ECHO=8'hEC, ADD=8'hAD, MUL=8'h88. DIV=8'hD1 and all other values are unsupported.
- Header states: RX_OPCODE -> RX_RESERVED -> RX_LENGTH_LSB -> RX_LENGTH_MSB. Each advances on an rx handshake. rx_ready_o=1 in these states. The reserved byte is ignored.
- LEN is {MSB,LSB} and counts the whole packet including the header. Payload count P = LEN-4, or 0 if LEN<4.
- After the MSB byte, dispatch by opcode:
  - ECHO goes to ECHO.
  - ADD goes to ADD with acc=0.
  - MUL goes to MUL with acc=1.
  - Unsupported: pulse err_o the same cycle and go to DRAIN.
  - If P=0: ECHO returns to RX_OPCODE; ADD/MUL go straight to TRANSMIT.
- ECHO:
  - rx_ready_o = ~tx_valid_o.
  - A byte accepted in cycle N appears on tx_data_o with tx_valid_o=1 in cycle N+1.
  - After the P-th byte is sent, return to RX_OPCODE.
- ADD:
  - Payload bytes form little-endian OPERAND_W words.
  - acc <= acc + word, mod 2^OPERAND_W, carry discarded, one cycle after the word's last byte.
  - A trailing partial word is zero-extended in its missing upper bytes.
  - After P bytes, go to TRANSMIT.
- MUL:
  - Words are assembled the same way.
  - On word completion, go to MUL_WAIT with mul_a_o=acc, mul_b_o=word, mul_valid_o=1.
  - Drop mul_valid_o after the mul_valid_o&mul_ready_i handshake.
  - On mul_done_i: acc <= mul_result_i. If bytes remain, return to MUL; else go to TRANSMIT.
  - rx_ready_o=0 in MUL_WAIT.
  - mul_done_i outside MUL_WAIT is ignored.
- TRANSMIT:
  - Send acc as OPERAND_W/8 bytes, LSB first, each under valid/ready.
  - tx_data_o is stable while tx_valid_o=1 and tx_ready_i=0.
  - After the last byte is accepted, return to RX_OPCODE.
  - rx_ready_o=0.
- DRAIN: rx_ready_o=1. Discard P bytes, then return to RX_OPCODE.
- Back-to-back packets: the cycle after returning to RX_OPCODE, the next opcode may be accepted. No idle gap is required.
- rx_valid_i without rx_ready_o is held off by the source. The controller never drops a byte.

Test Plan:
- ECHO: EC 00 07 00 41 42 43 with tx_ready_i=1 -> tx bytes 41,42,43. Each tx_valid_o rises 1 cycle after the rx handshake. Back in RX_OPCODE after 43.
- ADD with wrap: AD 00 0C 00 FF FF FF FF 02 00 00 00 -> tx 01 00 00 00. Then AD 00 04 00 -> tx 00 00 00 00.
- MUL: 88 00 0C 00 03 00 00 00 05 00 00 00, with a model multiplier that has 3-cycle latency and holds mul_ready_i low for 2 cycles -> requests (1,3) and (3,5). rx stalled during MUL_WAIT. tx 0F 00 00 00.
- Unsupported: D1 00 06 00 AA BB, then EC 00 05 00 99 -> err_o pulses once, AA/BB produce no tx, tx 99 only.
- TX backpressure: ADD result with tx_ready_i toggled 0/1 pseudo-randomly -> tx_data_o stable while stalled, bytes in LSB-first order, no duplicates or drops.
- Reset mid-MUL: assert rst_i during MUL_WAIT -> all outputs 0 immediately. Then a fresh ECHO packet is processed correctly and late mul_done_i is ignored.
